// File: rtl/fifo_pkg.sv
// Shared constants for the 8-deep FIFO and its stream reader.
package fifo_pkg;
  localparam int BUF_WIDTH  = 3;
  localparam int BUF_SIZE   = 8;
  localparam int DATA_W     = 8;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream, grouped for the reader.
interface fifo_stream_reader_if #(
  parameter int DATA_W = fifo_pkg::DATA_W
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (input fifo_empty, fifo_data, m_ready,
                  output fifo_rd_en, m_valid, m_data);
  modport slave  (output fifo_empty, fifo_data, m_ready,
                  input fifo_rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry ordered buffer: head in buf0, pop shifts buf1 forward.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output occ_t              o_occ,
  output logic [DATA_W-1:0] o_head
);
  logic [DATA_W-1:0] r_buf0, r_buf1;
  occ_t              r_occ;
  logic              w_tail1;

  // Tail slot is computed after this cycle's pop has shifted the head.
  assign w_tail1 = (r_occ - {1'b0, i_pop}) == 2'd1;
  assign o_occ   = r_occ;
  assign o_head  = r_buf0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_occ  <= '0;
    end else if (i_flush) begin
      r_occ <= '0;
    end else begin
      if (i_pop)              r_buf0 <= r_buf1;
      if (i_push && !w_tail1) r_buf0 <= i_din;
      if (i_push && w_tail1)  r_buf1 <= i_din;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: credit-based FIFO strobes into a 2-entry skid buffer.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_flush,
  fifo_stream_reader_if.master bus,
  output logic [CNT_W-1:0]     o_xfer_count,
  output logic                 o_busy
);
  occ_t              w_occ;
  logic [DATA_W-1:0] w_head;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_xfer_count;
  logic              w_pop, w_push, w_rd_en;
  logic [2:0]        w_credit_use;

  assign w_pop        = bus.m_valid && bus.m_ready;
  // Slots committed once this cycle's pop retires; never goes negative
  // because a pop implies occ >= 1.
  assign w_credit_use = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_rd_en      = !rst && i_en && !i_flush && !bus.fifo_empty &&
                        (w_credit_use < 3'(SKID_DEPTH));
  assign w_push       = r_inflight && !i_flush;

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = (w_occ != 2'd0);
  assign bus.m_data     = w_head;
  assign o_xfer_count   = r_xfer_count;
  assign o_busy         = (w_occ != 2'd0) || r_inflight;

  skid_buf2 #(.DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_flush(i_flush),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (bus.fifo_data),
    .o_occ  (w_occ),
    .o_head (w_head)
  );

  // Flush clears the in-flight flag since rd_en is gated low that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight   <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) r_xfer_count <= r_xfer_count + CNT_W'(1);
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, w_occ} + {2'b0, r_inflight}) <= 3'(SKID_DEPTH));
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side adapter for the team's 8-deep synchronous FIFO. It issues rd_en pulses to the FIFO and accounts for the FIFO's registered buf_out, which has 1-cycle read latency. Returned words are captured into a 2-entry skid buffer and presented on a valid/ready stream to downstream consumers (UART TX, packetizer). Sustains one word per cycle with m_ready held high, never overruns its buffer, preserves order, and counts delivered words.

Parameters:
DATA_W, 8, width of FIFO word and stream data
CNT_W, 16, width of delivered-word counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  allow new FIFO reads; level sensitive
flush  input  1  synchronous discard of buffered and in-flight words
fifo_empty  input  1  FIFO empty flag (FIFO buf_empty)
fifo_data  input  DATA_W  FIFO registered read data (FIFO buf_out), valid the cycle after fifo_rd_en
fifo_rd_en  output  1  read strobe to FIFO (FIFO rd_en)
m_valid  output  1  stream word available
m_data  output  DATA_W  stream data, head of skid buffer
m_ready  input  1  downstream accepts when m_valid&&m_ready
xfer_count  output  CNT_W  number of accepted stream words, wraps
busy  output  1  occ!=0 or inflight

Behaviour:
- State: occ (0..2, entries held), inflight (1 = fifo_rd_en issued last cycle and not flushed), buf0 (head), buf1.
- Reset: occ=0, inflight=0, buf0=buf1=0, xfer_count=0. Outputs: m_valid=0, m_data=0, fifo_rd_en=0, busy=0.
- pop = m_valid && m_ready. m_valid = (occ!=0). m_data = buf0.
- fifo_rd_en is combinational: fifo_rd_en = en && !flush && !fifo_empty && (occ + inflight - pop) < 2. No registered path to FIFO. The FIFO's empty flag tracks its own counter, so back-to-back strobes are safe.
- Capture: if inflight and !flush, fifo_data is written at the tail. The tail is index occ-pop in {buf0,buf1}. Pop shifts buf1 into buf0 in the same cycle. occ_next = occ + inflight - pop.
- Simultaneous pop and capture with occ=1: the new word goes to buf0 and occ stays 1.
- Simultaneous pop and capture with occ=2: illegal by the credit rule. Add an assertion that occ+inflight never exceeds 2.
- inflight_next = fifo_rd_en.
- Throughput: with m_ready=1 and the FIFO non-empty, the first m_valid is 2 cycles after the first fifo_rd_en. Then one word per cycle.
- Backpressure: when m_ready drops, at most 2 words are held and fifo_rd_en deasserts. There is no data loss or duplication.
- m_data is stable while m_valid && !m_ready.
- en=0 mid-stream: no new reads. An in-flight word is still captured and buffered words still drain.
- flush=1: fifo_rd_en=0 that cycle, occ=0 and inflight=0 next cycle, and the in-flight word is dropped. A pop in the flush cycle still counts in xfer_count.
- fifo_empty asserted: no reads. If fifo_empty is deasserted with en=1 and credit available, a read is issued the same cycle.
- xfer_count increments on each pop and wraps 2^CNT_W-1 to 0.
- Reset mid-operation clears all state immediately (async). FIFO contents are not touched.

Decomposition:
- Shared package fifo_pkg: BUF_WIDTH=3, BUF_SIZE=8, DATA_W default, SKID_DEPTH=2 localparam.
- One natural sub-module: skid_buf2, the 2-entry ordered buffer with push/pop/occ. The credit logic, flush and counter stay in the top module.

Test Plan:
1. Fill FIFO with 0x11..0x18, en=1, m_ready=1:
   - fifo_rd_en high 8 consecutive cycles.
   - m_data 0x11..0x18 on 8 consecutive cycles starting 2 cycles after the first strobe.
   - xfer_count=8, busy=0 at end.
2. 8 words, m_ready toggled 1,0,0,1 repeating:
   - Order is preserved with no duplicates.
   - occ never exceeds 2.
   - m_data is held while stalled.
   - fifo_rd_en is low whenever occ+inflight-pop=2.
3. FIFO empty with en=1:
   - fifo_rd_en=0 and m_valid=0.
   - Write 0xA5: fifo_rd_en pulses once, then m_valid with 0xA5 two cycles later.
4. 4 words queued, m_ready=0; assert flush on the cycle after the second strobe:
   - m_valid=0 next cycle.
   - The remaining 2 FIFO words (0x13, 0x14) are delivered after m_ready=1.
5. Preload xfer_count to 0xFFFF by 65535 transfers (or force), then deliver 2 words -> xfer_count reads 0x0001.
6. Assert rst mid-burst with occ=2 -> all outputs read 0 immediately (asynchronous), and the next read after deassert returns the next FIFO word.
